sar_seq: RTL
============

# sar_seq

Conversion sequencer for the synchronous SAR ADC controller. It scans the enabled analog channels round-robin, runs the track/convert cycle for each conversion, and averages 2^AVG_LOG2 conversions per channel. Averaged results are delivered through a valid/ready port. It sits between the register/DSP side and the SAR controller: it drives that controller's active-low reset to start each conversion and captures its result on the last-cycle flag.

## Interface
- N, 12, SAR resolution in bits
- NCH, 4, number of analog channels
- CHW, 2, channel index width; requires 2^CHW >= NCH
- TRACK_CYC, 4, track (sample) phase length in clocks; must be >= 1
- AVG_LOG2, 2, log2 of conversions averaged per result; 0 disables averaging

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  scan enable
- ch_mask  in  NCH  enabled channels; bit i selects channel i
- sar_rst_n  out  1  reset to the SAR controller; high only during conversion
- sar_last  in  1  SAR controller last-cycle flag
- sar_dq  in  N  SAR controller result; valid when sar_last=1
- ch_sel  out  CHW  analog mux select
- track  out  1  sample switch closed
- res_data  out  N  averaged result
- res_ch  out  CHW  channel of res_data
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- ovf  out  1  sticky; an unconsumed result was overwritten
- ovf_clr  in  1  clears ovf
- wdog_err  out  1  sticky; conversion timeout (see Configuration)

## Operation
- States: IDLE, TRACK, CONV, DONE.
- IDLE:
  - Outputs: sar_rst_n=0, track=0.
  - If en=1 and ch_mask is not zero: ch_sel <= lowest enabled channel at or after the channel pointer, with wrap-around. Go to TRACK.
- TRACK:
  - Outputs: track=1, sar_rst_n=0.
  - Runs for exactly TRACK_CYC cycles, then goes to CONV.
- CONV:
  - Outputs: track=0, sar_rst_n=1.
  - On the edge where sar_last=1: acc <= acc + sar_dq, then go to DONE.
  - sar_rst_n returns to 0 in DONE.
- DONE (1 cycle): bcnt increments.
  - If bcnt is at its final value (2^AVG_LOG2-1): publish, clear acc and bcnt, and advance the pointer to the next enabled channel after ch_sel, with wrap.
  - Otherwise the same channel is kept.
  - Next state is TRACK if en=1 and ch_mask is not zero. Otherwise go to IDLE and clear acc and bcnt, so a partial batch is discarded.
- Publish:
  - res_data <= acc_final[N+AVG_LOG2-1:AVG_LOG2] (truncating divide). acc is N+AVG_LOG2 bits wide and cannot overflow.
  - res_ch <= ch_sel, res_valid <= 1.
  - If res_valid=1 and res_ready=0 on that edge, the old result is overwritten and ovf <= 1.
  - res_valid=1 with res_ready=1 on the publish edge: the new result loads, no ovf.
- Handshake:
  - res_valid clears on the edge where res_valid=1 and res_ready=1, unless a publish occurs on the same edge.
  - res_data and res_ch stay stable while res_valid=1, except on an overwrite.
- ovf_clr=1 clears ovf. A simultaneous overwrite wins, so ovf stays 1.
- ch_mask is sampled only at channel selection (IDLE exit, and DONE when publishing).
- en=0 never aborts an in-flight TRACK or CONV.

## Timing
- Reset values: sar_rst_n=0, track=0, ch_sel=0, res_data=0, res_ch=0, res_valid=0, ovf=0, wdog_err=0. Channel pointer, acc and bcnt are 0, and the state is IDLE.
- Reset assertion mid-operation forces these values immediately (asynchronously). Deassertion is synchronized by the integrator.
- en to first track=1: 1 clock.
- Per conversion: TRACK_CYC + Tconv + 1 clocks, where Tconv = CONV cycles up to and including sar_last.
- Per result: 2^AVG_LOG2 conversions. res_valid rises on the edge leaving DONE.

## Configuration
- SAR_SEQ_WDOG_EN defined:
  - A CONV-state counter aborts the conversion if sar_last is not seen within N+4 cycles.
  - On abort: wdog_err <= 1 (sticky until reset), acc and bcnt clear, no publish. The channel pointer advances, and the next state follows the DONE rules.
- SAR_SEQ_WDOG_EN undefined: no counter, CONV waits indefinitely, and wdog_err is tied to 0.

## Test plan
All scenarios use the default parameters; the SAR model asserts sar_last on the 13th CONV cycle.
- Reset mid-CONV -> next sample: sar_rst_n=0, track=0, res_valid=0, state IDLE. With en held at 1, track=1 follows 1 cycle after deassertion.
- ch_mask=4'b0101, en=1, sar_dq=0x800, res_ready=1 -> res_ch sequence 0,2,0,2 with res_data=0x800. Results are 4*(4+13+1)=72 clocks apart.
- sar_dq sequence 0x100,0x101,0x102,0x103 on one channel -> a single result with res_data=0x101 (0x406>>2).
- res_ready=0 across two results -> ovf=1 and res_data holds the second result. Then ovf_clr=1 for one cycle -> ovf=0, and res_ready=1 clears res_valid.
- en dropped during the 2nd conversion of a batch -> that conversion finishes, then IDLE with no result. Re-enabling yields a full 4-conversion batch.
- With SAR_SEQ_WDOG_EN defined, sar_last held at 0 -> after 16 CONV cycles wdog_err=1, sar_rst_n=0, no res_valid, and the scan continues on the next channel.

Source files
------------

// File: rtl/sar_seq.sv
// Round-robin SAR conversion sequencer: track/convert timing, 2^AVG_LOG2 averaging, valid/ready result port.
// Optional conversion watchdog enabled by defining SAR_SEQ_WDOG_EN.
module sar_seq #(
  parameter int N         = 12,
  parameter int NCH       = 4,
  parameter int CHW       = 2,
  parameter int TRACK_CYC = 4,
  parameter int AVG_LOG2  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [NCH-1:0] ch_mask,
  output logic           sar_rst_n,
  input  logic           sar_last,
  input  logic [N-1:0]   sar_dq,
  output logic [CHW-1:0] ch_sel,
  output logic           track,
  output logic [N-1:0]   res_data,
  output logic [CHW-1:0] res_ch,
  output logic           res_valid,
  input  logic           res_ready,
  output logic           ovf,
  input  logic           ovf_clr,
  output logic           wdog_err
);

  localparam int AW  = N + AVG_LOG2;
  localparam int BW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int TCW = (TRACK_CYC > 1) ? $clog2(TRACK_CYC) : 1;
  localparam logic [BW-1:0]  BCNT_LAST = BW'((1 << AVG_LOG2) - 1);
  localparam logic [TCW-1:0] TCNT_LAST = TCW'(TRACK_CYC - 1);
`ifdef SAR_SEQ_WDOG_EN
  localparam int WCW = $clog2(N + 4);
  localparam logic [WCW-1:0] WCNT_LAST = WCW'(N + 3);
`endif

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_CONV, S_DONE} state_t;

  state_t         r_state;
  logic [CHW-1:0] r_ptr;
  logic [CHW-1:0] r_ch_sel;
  logic [AW-1:0]  r_acc;
  logic [BW-1:0]  r_bcnt;
  logic [TCW-1:0] r_tcnt;
  logic           r_track;
  logic           r_sar_rst_n;
  logic [N-1:0]   r_res_data;
  logic [CHW-1:0] r_res_ch;
  logic           r_res_valid;
  logic           r_ovf;
`ifdef SAR_SEQ_WDOG_EN
  logic [WCW-1:0] r_wcnt;
  logic           r_abort;
  logic           r_wdog_err;
`endif

  logic           w_go;
  logic           w_abort;
  logic           w_batch_end;
  logic           w_publish;
  logic [CHW-1:0] w_first;
  logic [CHW-1:0] w_next;

  // Lowest enabled channel at or after start, wrapping; returns start when no channel is enabled.
  function automatic logic [CHW-1:0] f_find(input logic [NCH-1:0] mask, input logic [CHW-1:0] start);
    logic [CHW-1:0] idx;
    logic           found;
    f_find = start;
    found  = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      idx = CHW'((int'(start) + k) % NCH);
      if (!found && mask[idx]) begin
        f_find = idx;
        found  = 1'b1;
      end
    end
  endfunction

  assign w_go        = en & (|ch_mask);
  assign w_first     = f_find(ch_mask, r_ptr);
  assign w_next      = f_find(ch_mask, CHW'((int'(r_ch_sel) + 1) % NCH));
  assign w_batch_end = (r_bcnt == BCNT_LAST);
  assign w_publish   = w_batch_end & ~w_abort;

`ifdef SAR_SEQ_WDOG_EN
  assign w_abort  = r_abort;
  assign wdog_err = r_wdog_err;
`else
  assign w_abort  = 1'b0;
  assign wdog_err = 1'b0;
`endif

  assign sar_rst_n = r_sar_rst_n;
  assign track     = r_track;
  assign ch_sel    = r_ch_sel;
  assign res_data  = r_res_data;
  assign res_ch    = r_res_ch;
  assign res_valid = r_res_valid;
  assign ovf       = r_ovf;

  // Sequencer FSM with accumulator, result port and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_ch_sel    <= '0;
      r_acc       <= '0;
      r_bcnt      <= '0;
      r_tcnt      <= '0;
      r_track     <= 1'b0;
      r_sar_rst_n <= 1'b0;
      r_res_data  <= '0;
      r_res_ch    <= '0;
      r_res_valid <= 1'b0;
      r_ovf       <= 1'b0;
`ifdef SAR_SEQ_WDOG_EN
      r_wcnt      <= '0;
      r_abort     <= 1'b0;
      r_wdog_err  <= 1'b0;
`endif
    end else begin
      // Handshake and clear go first so a same-edge publish/overwrite wins.
      if (ovf_clr) r_ovf <= 1'b0;
      if (r_res_valid && res_ready) r_res_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_track     <= 1'b0;
          r_sar_rst_n <= 1'b0;
          if (w_go) begin
            r_ch_sel <= w_first;
            r_tcnt   <= '0;
            r_track  <= 1'b1;
            r_state  <= S_TRACK;
          end
        end
        S_TRACK: begin
          if (r_tcnt == TCNT_LAST) begin
            r_track     <= 1'b0;
            r_sar_rst_n <= 1'b1;
`ifdef SAR_SEQ_WDOG_EN
            r_wcnt      <= '0;
`endif
            r_state     <= S_CONV;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_CONV: begin
          if (sar_last) begin
            r_acc       <= r_acc + AW'(sar_dq);
            r_sar_rst_n <= 1'b0;
            r_state     <= S_DONE;
          end
`ifdef SAR_SEQ_WDOG_EN
          else if (r_wcnt == WCNT_LAST) begin
            r_abort     <= 1'b1;
            r_wdog_err  <= 1'b1;
            r_sar_rst_n <= 1'b0;
            r_state     <= S_DONE;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          if (w_abort || w_batch_end) begin
            r_acc    <= '0;
            r_bcnt   <= '0;
            r_ptr    <= w_next;
            r_ch_sel <= w_next;
          end else begin
            r_bcnt <= r_bcnt + 1'b1;
          end
          if (w_publish) begin
            r_res_data  <= r_acc[AW-1:AVG_LOG2];
            r_res_ch    <= r_ch_sel;
            r_res_valid <= 1'b1;
            if (r_res_valid && !res_ready) r_ovf <= 1'b1;
          end
`ifdef SAR_SEQ_WDOG_EN
          r_abort <= 1'b0;
`endif
          if (w_go) begin
            r_tcnt  <= '0;
            r_track <= 1'b1;
            r_state <= S_TRACK;
          end else begin
            // A partial batch is discarded when the scan stops.
            r_acc   <= '0;
            r_bcnt  <= '0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_track     <= 1'b0;
          r_sar_rst_n <= 1'b0;
        end
      endcase
    end
  end

endmodule
